// File: rtl/onehot_to_binary_enc.sv
// One-hot to binary encoder with strict one-hot checking, running counters and a
// 2-entry output buffer so a stalled consumer never backpressures combinationally.
module onehot_to_binary_enc #(
    parameter int unsigned WID        = 4,
    parameter int unsigned RESULT_WID = 16,
    parameter int unsigned CNT_WID    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RESULT_WID-1:0] onehot_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WID-1:0]        bin_out,
    output logic                  out_err,
    output logic [CNT_WID-1:0]    word_count,
    output logic [CNT_WID-1:0]    err_count
);

    localparam int unsigned CNT_ENT_W = 2;

    logic [WID-1:0]        w_idx;
    logic                  w_zero;
    logic                  w_multi;
    logic                  w_err;
    logic                  w_accept;
    logic                  w_pop;
    logic [CNT_ENT_W-1:0]  w_count_nxt;
    logic [WID-1:0]        w_head_bin_nxt;
    logic                  w_head_err_nxt;
    logic [WID-1:0]        w_tail_bin_nxt;
    logic                  w_tail_err_nxt;

    logic [CNT_ENT_W-1:0]  r_count;
    logic [WID-1:0]        r_head_bin;
    logic                  r_head_err;
    logic [WID-1:0]        r_tail_bin;
    logic                  r_tail_err;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [CNT_WID-1:0]    r_word_count;
    logic [CNT_WID-1:0]    r_err_count;

    // Lowest set bit wins; the downward scan leaves the lowest index last.
    always_comb begin
        w_idx = '0;
        for (int i = int'(RESULT_WID) - 1; i >= 0; i--) begin
            if (onehot_in[i]) begin
                w_idx = WID'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; anything left means two or more bits set.
    assign w_zero   = (onehot_in == '0);
    assign w_multi  = |(onehot_in & (onehot_in - RESULT_WID'(1)));
    assign w_err    = w_zero | w_multi;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_out_valid & out_ready;

    // Buffer next state: head is always entry 0, tail only meaningful at count 2.
    always_comb begin
        w_count_nxt    = r_count;
        w_head_bin_nxt = r_head_bin;
        w_head_err_nxt = r_head_err;
        w_tail_bin_nxt = r_tail_bin;
        w_tail_err_nxt = r_tail_err;
        case (r_count)
            2'd0: begin
                if (w_accept) begin
                    w_head_bin_nxt = w_idx;
                    w_head_err_nxt = w_err;
                    w_count_nxt    = 2'd1;
                end
            end
            2'd1: begin
                if (w_accept && w_pop) begin
                    w_head_bin_nxt = w_idx;
                    w_head_err_nxt = w_err;
                end else if (w_accept) begin
                    w_tail_bin_nxt = w_idx;
                    w_tail_err_nxt = w_err;
                    w_count_nxt    = 2'd2;
                end else if (w_pop) begin
                    w_count_nxt    = 2'd0;
                end
            end
            default: begin
                if (w_pop) begin
                    w_head_bin_nxt = r_tail_bin;
                    w_head_err_nxt = r_tail_err;
                    w_count_nxt    = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_head_bin   <= '0;
            r_head_err   <= 1'b0;
            r_tail_bin   <= '0;
            r_tail_err   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_word_count <= '0;
            r_err_count  <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_head_bin  <= w_head_bin_nxt;
            r_head_err  <= w_head_err_nxt;
            r_tail_bin  <= w_tail_bin_nxt;
            r_tail_err  <= w_tail_err_nxt;
            r_in_ready  <= (w_count_nxt != 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
            if (w_accept) begin
                r_word_count <= r_word_count + CNT_WID'(1);
                if (w_err && (r_err_count != {CNT_WID{1'b1}})) begin
                    r_err_count <= r_err_count + CNT_WID'(1);
                end
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign bin_out    = r_head_bin;
    assign out_err    = r_head_err;
    assign word_count = r_word_count;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_onehot_to_binary_enc.sv
// Scoreboard bench for onehot_to_binary_enc: stimulus pushes hand-computed results,
// an independent monitor pops and compares on every output handshake.
module tb_onehot_to_binary_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] onehot_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  bin_out;
    logic        out_err;
    logic [7:0]  word_count;
    logic [7:0]  err_count;

    typedef struct packed {
        logic [3:0] bin;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    onehot_to_binary_enc #(.WID(4), .RESULT_WID(16), .CNT_WID(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .onehot_in  (onehot_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bin_out    (bin_out),
        .out_err    (out_err),
        .word_count (word_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present a word until accepted; the expected result is queued at the accepting edge.
    task automatic send_word(input logic [15:0] w, input logic [3:0] eb, input logic ee,
                             input bit chk_ov);
        int t = 0;
        bit done = 1'b0;
        in_valid  = 1'b1;
        onehot_in = w;
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                q.push_back({eb, ee});
                if (chk_ov) check("ov_stream", 32'(out_valid), 32'd1);
                done = 1'b1;
            end else if (++t > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: word %0h never accepted", w);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        onehot_in = '0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid !== 1'b0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries still expected", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a pop happens on the next rising edge, so the head is compared now.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_output: bin %0h err %0b with nothing expected",
                         bin_out, out_err);
            end else begin
                e = q.pop_front();
                check("sb_bin", 32'(bin_out), 32'(e.bin));
                check("sb_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] vec_w[5];
    logic [3:0]  vec_b[5];

    initial begin
        vec_w[0] = 16'h0000; vec_b[0] = 4'd0;
        vec_w[1] = 16'hFFFF; vec_b[1] = 4'd0;
        vec_w[2] = 16'h8100; vec_b[2] = 4'd8;
        vec_w[3] = 16'h0006; vec_b[3] = 4'd1;
        vec_w[4] = 16'hA000; vec_b[4] = 4'd13;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        onehot_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_bin_out",   32'(bin_out),    32'd0);
        check("rst_out_err",   32'(out_err),    32'd0);
        check("rst_word_cnt",  32'(word_count), 32'd0);
        check("rst_err_cnt",   32'(err_count),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Walking-one sweep, streaming
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_word(16'h0001 << i, 4'(i), 1'b0, i != 0);
        end
        drain();
        check("sweep_word_cnt", 32'(word_count), 32'd16);
        check("sweep_err_cnt",  32'(err_count),  32'd0);

        // Zero and multi-hot words
        send_word(16'h0000, 4'd0, 1'b1, 1'b0);
        send_word(16'h0012, 4'd1, 1'b1, 1'b0);
        drain();
        check("err_word_cnt", 32'(word_count), 32'd18);
        check("err_err_cnt",  32'(err_count),  32'd2);

        // Fill the buffer against a stalled consumer
        out_ready = 1'b0;
        send_word(16'h0004, 4'd2, 1'b0, 1'b0);
        send_word(16'h0008, 4'd3, 1'b0, 1'b0);
        in_valid  = 1'b1;
        onehot_in = 16'h0010;
        @(negedge clk);
        check("full_in_ready",  32'(in_ready),  32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_head_bin",  32'(bin_out),   32'd2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready),   32'd0);
        check("stall_head_bin", 32'(bin_out),    32'd2);
        check("stall_word_cnt", 32'(word_count), 32'd20);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_word(16'h0010, 4'd4, 1'b0, 1'b0);
        drain();
        check("full_word_cnt", 32'(word_count), 32'd21);

        // Simultaneous accept and pop at count 1
        for (int i = 5; i < 14; i++) begin
            send_word(16'h0001 << i, 4'(i), 1'b0, i != 5);
        end
        drain();
        check("pass_word_cnt", 32'(word_count), 32'd30);

        // Counter wrap and saturation from a fresh reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst2_word_cnt", 32'(word_count), 32'd0);
        for (int k = 0; k < 300; k++) begin
            send_word(vec_w[k % 5], vec_b[k % 5], 1'b1, 1'b0);
            if (k == 253) check("sat_err_254", 32'(err_count), 32'd254);
            if (k == 254) check("sat_err_255", 32'(err_count), 32'd255);
            if (k == 255) check("wrap_word_0", 32'(word_count), 32'd0);
        end
        drain();
        check("sat_err_hold", 32'(err_count),  32'd255);
        check("wrap_word_44", 32'(word_count), 32'd44);

        // Reset with two entries buffered
        out_ready = 1'b0;
        send_word(16'h0002, 4'd1,  1'b0, 1'b0);
        send_word(16'h0800, 4'd11, 1'b0, 1'b0);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid),  32'd0);
        check("mid_rst_in_ready",  32'(in_ready),   32'd1);
        check("mid_rst_word_cnt",  32'(word_count), 32'd0);
        check("mid_rst_err_cnt",   32'(err_count),  32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send_word(16'h4000, 4'd14, 1'b0, 1'b0);
        drain();
        check("post_rst_word_cnt", 32'(word_count), 32'd1);
        check("post_rst_err_cnt",  32'(err_count),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
